// File: rtl/tile_pkg.sv
// Shared tile-map definitions: tile types, map geometry and the level ROM contents.
// The ROM is built by a constant function so each level reads as a readable rule set.
package tile_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      BRICK  = 2'd1,
      SPRING = 2'd2,
      STAR   = 2'd3
   } tile_type_e;

   localparam int MAP_DIM    = 8;
   localparam int MAP_SIZE   = 64;
   localparam int NUM_LEVELS = 4;

   typedef logic [NUM_LEVELS-1:0][MAP_SIZE-1:0][1:0] level_rom_t;

   function automatic logic [5:0] tileIndex(input logic [2:0] x, input logic [2:0] y);
      return {y, x};
   endfunction

   // Layout rules per level; later rules override earlier ones on the same tile.
   function automatic logic [1:0] levelTile(input int lvl, input int x, input int y);
      logic [1:0] t;
      t = EMPTY;
      case (lvl)
         0: begin
            if (y == 7) t = BRICK;
            if ((x == 5 && y == 2) || (x == 1 && y == 6)) t = STAR;
            if (x == 3 && y == 6) t = SPRING;
         end
         1: begin
            if (y == 7) t = BRICK;
            if (y == 1 && (x % 2) == 0) t = STAR;
            if (x == 0 && y == 5) t = SPRING;
         end
         2: begin
            if (y == 7) t = BRICK;
            if (y == 4 && x != 3 && x != 4) t = BRICK;
            if (x == y && y < 4) t = STAR;
            if (x == 6 && y == 6) t = SPRING;
         end
         default: begin
            if (x == 0 || x == 7 || y == 7) t = BRICK;
            if ((x == 2 || x == 5) && (y == 2 || y == 5)) t = STAR;
            if ((x == 3 || x == 4) && y == 6) t = SPRING;
         end
      endcase
      return t;
   endfunction

   function automatic level_rom_t buildLevelRom();
      level_rom_t rom;
      rom = '0;
      for (int l = 0; l < NUM_LEVELS; l++) begin
         for (int i = 0; i < MAP_SIZE; i++) begin
            rom[l][i] = levelTile(l, i % MAP_DIM, i / MAP_DIM);
         end
      end
      return rom;
   endfunction

   localparam level_rom_t LEVEL_ROM = buildLevelRom();

endpackage

// File: rtl/tile_level_rom.sv
// Combinational level ROM lookup: returns the tile stored for a level at a map index.
module tile_level_rom
   import tile_pkg::*;
(
   input  logic [1:0] level,
   input  logic [5:0] idx,
   output logic [1:0] tile
);

   assign tile = LEVEL_ROM[level][idx];

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map controller: loads a level from ROM one tile per cycle, serves display
// reads with one cycle of latency, and resolves ball hits by clearing stars.
module tile_map_ctrl
   import tile_pkg::*;
#(
   parameter bit AUTO_LOAD = 1'b0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [2:0] Xnum,
   input  logic [2:0] Ynum,
   output logic [1:0] Tile_Type,
   input  logic       loadReq,
   input  logic [1:0] level,
   output logic       busy,
   output logic       loadDone,
   input  logic       hitReq,
   input  logic [2:0] hitX,
   input  logic [2:0] hitY,
   output logic       hitAck,
   output logic       hitStar,
   output logic [6:0] starsLeft,
   output logic       levelClear
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOAD = 1'b1;

   logic [0:0]             state;
   logic [5:0]             cnt;
   logic [1:0]             levelLatched;
   logic                   loaded;
   logic                   autoPending;
   logic [MAP_SIZE-1:0][1:0] mapReg;
   logic [1:0]             tileReg;

   logic       startLoad;
   logic [1:0] startLevel;
   logic       acceptHit;
   logic [5:0] hitIdx;
   logic [5:0] rdIdx;
   logic [1:0] hitTile;
   logic [1:0] romTile;

   tile_level_rom uRom (
      .level (levelLatched),
      .idx   (cnt),
      .tile  (romTile)
   );

   // An automatic post-reset load behaves exactly like a loadReq for level 0.
   assign startLoad  = (state == IDLE) && (loadReq || autoPending);
   assign startLevel = autoPending ? 2'd0 : level;
   assign acceptHit  = hitReq && (state == IDLE) && !startLoad;
   assign hitIdx     = tileIndex(hitX, hitY);
   assign rdIdx      = tileIndex(Xnum, Ynum);
   assign hitTile    = mapReg[hitIdx];

   assign busy       = (state == LOAD);
   assign Tile_Type  = busy ? 2'(EMPTY) : tileReg;
   assign levelClear = loaded && (starsLeft == 7'd0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         cnt          <= '0;
         levelLatched <= '0;
         loaded       <= 1'b0;
         loadDone     <= 1'b0;
         autoPending  <= AUTO_LOAD;
         starsLeft    <= '0;
         mapReg       <= '0;
      end else begin
         loadDone <= 1'b0;
         if (startLoad) begin
            state        <= LOAD;
            levelLatched <= startLevel;
            cnt          <= '0;
            starsLeft    <= '0;
            loaded       <= 1'b0;
            autoPending  <= 1'b0;
         end else if (state == LOAD) begin
            mapReg[cnt] <= romTile;
            if (romTile == STAR) starsLeft <= starsLeft + 7'd1;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) begin
               state    <= IDLE;
               loadDone <= 1'b1;
               loaded   <= 1'b1;
            end
         end else if (acceptHit && hitTile == STAR) begin
            mapReg[hitIdx] <= EMPTY;
            if (starsLeft != 7'd0) starsLeft <= starsLeft - 7'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hitAck  <= 1'b0;
         hitStar <= 1'b0;
         tileReg <= '0;
      end else begin
         hitAck  <= acceptHit;
         hitStar <= acceptHit && (hitTile == STAR);
         tileReg <= mapReg[rdIdx];
      end
   end

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Self-checking bench for tile_map_ctrl: table-driven reads and hits through a
// scoreboard queue, plus hand-written load, error and reset sequences.
module tb_tile_map_ctrl;

   logic       clk;
   logic       resetN;
   logic [2:0] Xnum;
   logic [2:0] Ynum;
   logic [1:0] Tile_Type;
   logic       loadReq;
   logic [1:0] level;
   logic       busy;
   logic       loadDone;
   logic       hitReq;
   logic [2:0] hitX;
   logic [2:0] hitY;
   logic       hitAck;
   logic       hitStar;
   logic [6:0] starsLeft;
   logic       levelClear;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] x;
      logic [2:0] y;
      int         exp;
   } readVec_t;

   typedef struct {
      logic [2:0] x;
      logic [2:0] y;
      int         expAck;
      int         expStar;
      int         expStars;
   } hitVec_t;

   readVec_t readTab[64];
   hitVec_t  hitTab[4];
   int       readQ[$];
   hitVec_t  hitQ[$];

   tile_map_ctrl dut (
      .clk        (clk),
      .resetN     (resetN),
      .Xnum       (Xnum),
      .Ynum       (Ynum),
      .Tile_Type  (Tile_Type),
      .loadReq    (loadReq),
      .level      (level),
      .busy       (busy),
      .loadDone   (loadDone),
      .hitReq     (hitReq),
      .hitX       (hitX),
      .hitY       (hitY),
      .hitAck     (hitAck),
      .hitStar    (hitStar),
      .starsLeft  (starsLeft),
      .levelClear (levelClear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent model of the level-0 layout.
   function automatic int expTile0(input int x, input int y);
      if (y == 7) return 1;
      if ((x == 5 && y == 2) || (x == 1 && y == 6)) return 3;
      if (x == 3 && y == 6) return 2;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] x, input logic [2:0] y, input int exp);
      int e;
      Xnum = x;
      Ynum = y;
      readQ.push_back(exp);
      tick();
      e = readQ.pop_front();
      checkOutput($sformatf("read(%0d,%0d)", x, y), int'(Tile_Type), e);
   endtask

   task automatic runLoad(input logic [1:0] lvl, input bit disturb,
                          output int busyCycles, output int doneCount, output int ackCount);
      loadReq = 1'b1;
      level   = lvl;
      tick();
      loadReq = 1'b0;
      busyCycles = 0;
      doneCount  = 0;
      ackCount   = 0;
      while (busy && busyCycles < 200) begin
         busyCycles++;
         if (disturb) begin
            hitReq  = (busyCycles == 10);
            hitX    = 3'd5;
            hitY    = 3'd2;
            loadReq = (busyCycles == 20);
            level   = 2'd1;
         end
         tick();
         if (loadDone) doneCount++;
         if (hitAck) ackCount++;
      end
      hitReq  = 1'b0;
      loadReq = 1'b0;
      tick();
      if (loadDone) doneCount++;
   endtask

   initial begin
      int bc, dc, ac;
      hitVec_t h;

      for (int i = 0; i < 64; i++) begin
         readTab[i].x   = 3'(i % 8);
         readTab[i].y   = 3'(i / 8);
         readTab[i].exp = expTile0(i % 8, i / 8);
      end
      hitTab[0] = '{x: 3'd5, y: 3'd2, expAck: 1, expStar: 1, expStars: 1};
      hitTab[1] = '{x: 3'd5, y: 3'd2, expAck: 1, expStar: 0, expStars: 1};
      hitTab[2] = '{x: 3'd7, y: 3'd7, expAck: 1, expStar: 0, expStars: 1};
      hitTab[3] = '{x: 3'd1, y: 3'd6, expAck: 1, expStar: 1, expStars: 0};

      resetN  = 1'b0;
      Xnum    = '0;
      Ynum    = '0;
      loadReq = 1'b0;
      level   = '0;
      hitReq  = 1'b0;
      hitX    = '0;
      hitY    = '0;
      #12;
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset loadDone", int'(loadDone), 0);
      checkOutput("reset hitAck", int'(hitAck), 0);
      checkOutput("reset hitStar", int'(hitStar), 0);
      checkOutput("reset starsLeft", int'(starsLeft), 0);
      checkOutput("reset levelClear", int'(levelClear), 0);
      checkOutput("reset Tile_Type", int'(Tile_Type), 0);
      resetN = 1'b1;
      tick();
      tick();
      checkOutput("no autoload busy", int'(busy), 0);

      $display("[TB] load level 0");
      runLoad(2'd0, 1'b0, bc, dc, ac);
      checkOutput("load0 busy cycles", bc, 64);
      checkOutput("load0 loadDone pulses", dc, 1);
      checkOutput("load0 starsLeft", int'(starsLeft), 2);
      checkOutput("load0 levelClear", int'(levelClear), 0);

      $display("[TB] sweep level 0 map");
      for (int i = 0; i < 64; i++) applyStimulus(readTab[i].x, readTab[i].y, readTab[i].exp);

      applyStimulus(3'd0, 3'd7, 1);
      Xnum = 3'd5;
      Ynum = 3'd2;
      #2;
      checkOutput("read latency hold", int'(Tile_Type), 1);
      tick();
      checkOutput("read latency update", int'(Tile_Type), 3);

      $display("[TB] back-to-back hits");
      for (int i = 0; i < 4; i++) begin
         hitReq = 1'b1;
         hitX   = hitTab[i].x;
         hitY   = hitTab[i].y;
         hitQ.push_back(hitTab[i]);
         tick();
         h = hitQ.pop_front();
         checkOutput($sformatf("hit%0d hitAck", i), int'(hitAck), h.expAck);
         checkOutput($sformatf("hit%0d hitStar", i), int'(hitStar), h.expStar);
         checkOutput($sformatf("hit%0d starsLeft", i), int'(starsLeft), h.expStars);
      end
      hitReq = 1'b0;
      tick();
      checkOutput("hit idle hitAck", int'(hitAck), 0);
      checkOutput("all stars levelClear", int'(levelClear), 1);
      applyStimulus(3'd5, 3'd2, 0);
      applyStimulus(3'd7, 3'd7, 1);
      applyStimulus(3'd1, 3'd6, 0);
      applyStimulus(3'd3, 3'd6, 2);

      $display("[TB] reload with hit and loadReq during load");
      runLoad(2'd0, 1'b1, bc, dc, ac);
      checkOutput("disturbed busy cycles", bc, 64);
      checkOutput("disturbed loadDone pulses", dc, 1);
      checkOutput("disturbed hitAck count", ac, 0);
      checkOutput("disturbed starsLeft", int'(starsLeft), 2);
      applyStimulus(3'd5, 3'd2, 3);

      $display("[TB] loadReq and hitReq in the same cycle");
      loadReq = 1'b1;
      level   = 2'd1;
      hitReq  = 1'b1;
      hitX    = 3'd1;
      hitY    = 3'd6;
      tick();
      loadReq = 1'b0;
      hitReq  = 1'b0;
      checkOutput("same-cycle busy", int'(busy), 1);
      checkOutput("same-cycle hitAck", int'(hitAck), 0);
      bc = 0;
      while (busy && bc < 200) begin
         bc++;
         tick();
      end
      checkOutput("level1 busy cycles", bc, 64);
      // Level 1 places stars at even columns of row 1.
      checkOutput("level1 starsLeft", int'(starsLeft), 4);

      $display("[TB] reset during load");
      loadReq = 1'b1;
      level   = 2'd0;
      tick();
      loadReq = 1'b0;
      for (int c = 0; c < 30; c++) tick();
      resetN = 1'b0;
      #1;
      checkOutput("midload reset busy", int'(busy), 0);
      checkOutput("midload reset starsLeft", int'(starsLeft), 0);
      checkOutput("midload reset levelClear", int'(levelClear), 0);
      checkOutput("midload reset Tile_Type", int'(Tile_Type), 0);
      #1;
      resetN = 1'b1;
      tick();
      tick();
      checkOutput("after reset no resume", int'(busy), 0);
      for (int i = 0; i < 64; i++) applyStimulus(readTab[i].x, readTab[i].y, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tile_map_ctrl.md
TILE_MAP_CTRL -- requirements
Module: tile_map_ctrl

Interface
REQ-001 Parameter AUTO_LOAD, default 0: when 1, a load of level 0 starts automatically in the first cycle after reset release.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 resetN  input  1  reset, asynchronous, active-low.
REQ-004 Xnum  input  3  display-side tile column, 0..7.
REQ-005 Ynum  input  3  display-side tile row, 0..7.
REQ-006 Tile_Type  output  2  registered tile type at (Xnum,Ynum); 0 empty, 1 brick, 2 spring, 3 star.
REQ-007 loadReq  input  1  single-cycle pulse requesting a level load.
REQ-008 level  input  2  level index, sampled with loadReq.
REQ-009 busy  output  1  high while a load is in progress.
REQ-010 loadDone  output  1  one-cycle pulse at load completion.
REQ-011 hitReq  input  1  single-cycle pulse: the ball touched tile (hitX,hitY).
REQ-012 hitX, hitY  input  3 each  tile coordinates of the hit.
REQ-013 hitAck  output  1  one-cycle pulse answering an accepted hitReq.
REQ-014 hitStar  output  1  valid with hitAck: the hit tile was a star.
REQ-015 starsLeft  output  7  stars remaining in the map, 0..64.
REQ-016 levelClear  output  1  high when a level is loaded and starsLeft==0.

Function
REQ-017 The map SHALL hold 64 entries of 2 bits, indexed idx = y*8 + x.
REQ-018 Tile_Type SHALL equal map[Ynum*8+Xnum] one cycle after Xnum/Ynum are presented; it is forced to 0 while busy.
REQ-019 FSM states SHALL be IDLE and LOAD.
- IDLE -> LOAD on loadReq.
- LOAD -> IDLE after index 63 is written.
REQ-020 On entering LOAD: level is latched; load counter, starsLeft and the loaded flag are cleared.
REQ-021 In LOAD, one tile per cycle SHALL be written from the level ROM, index 0..63 in order; busy is high for exactly 64 cycles, starting the cycle after loadReq.
REQ-022 starsLeft SHALL increment for every star written during LOAD.
REQ-023 loadDone SHALL pulse, and the loaded flag SHALL set, in the cycle after the index-63 write.
REQ-024 loadReq while busy SHALL be ignored.
REQ-025 hitReq in IDLE SHALL be accepted. In the next cycle:
- hitAck=1;
- hitStar=1 if map[hitY*8+hitX]==3.
REQ-026 An accepted hit on a star SHALL clear that entry to 0 and decrement starsLeft by 1, visible the cycle after hitAck. Hits on other types leave the map unchanged.
REQ-027 hitReq while busy, or in the same cycle as an accepted loadReq, SHALL be dropped: no hitAck and no map change.
REQ-028 starsLeft SHALL never decrement below 0.
REQ-029 levelClear SHALL be combinational: loaded flag AND starsLeft==0.
REQ-030 Back-to-back hitReq on consecutive cycles SHALL each be acknowledged. A second hit on a just-cleared star reports hitStar=0.

Reset
REQ-031 Reset SHALL drive the following to their values immediately and asynchronously:
- map all 0; Tile_Type 0;
- FSM IDLE; busy 0; loadDone 0; hitAck 0; hitStar 0;
- starsLeft 0; loaded flag 0, so levelClear is 0.
REQ-032 Reset asserted mid-LOAD SHALL abort the load. No load resumes after reset unless AUTO_LOAD=1.

Structure
REQ-033 Package tile_pkg SHALL hold:
- the tile-type enum (EMPTY, BRICK, SPRING, STAR);
- MAP_DIM=8 and MAP_SIZE=64;
- LEVEL_ROM, a constant of 4 levels x 64 entries.
REQ-034 Level 0 of LEVEL_ROM SHALL be:
- row 7 all BRICK;
- STAR at (x5,y2) and at (x1,y6);
- SPRING at (x3,y6);
- all other entries EMPTY.
REQ-035 One sub-module, tile_level_rom, SHALL provide a combinational lookup of LEVEL_ROM by level and index.

Verification
REQ-036 Reset, then loadReq with level=0:
- busy high for 64 cycles;
- loadDone pulses once;
- starsLeft=2; levelClear=0.
REQ-037 After level 0 is loaded, sweep all 64 Xnum/Ynum values:
- Tile_Type=1 on row 7; 3 at (5,2) and (1,6); 2 at (3,6); 0 elsewhere;
- every read has 1-cycle latency.
REQ-038 hitReq at (5,2) -> hitAck with hitStar=1; starsLeft=1; a read of (5,2) returns 0. Repeat the hit -> hitStar=0, starsLeft stays 1.
REQ-039 Hit (7,7), the brick -> hitStar=0 and the map is unchanged. Then hit (1,6) -> starsLeft=0 and levelClear=1.
REQ-040 Error cases during and around loads:
- hitReq at cycle 10 of a load -> no hitAck;
- loadReq at cycle 20 of a load -> ignored, load still ends at cycle 64;
- loadReq and hitReq in the same IDLE cycle -> load starts and the hit is dropped.
REQ-041 Reset asserted at load cycle 30 -> busy=0, starsLeft=0, and all Tile_Type reads return 0.
